// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and helpers for the sequential fully-connected neuron
package fc_pkg;

    typedef enum logic {
        ACT_NONE = 1'b0,
        ACT_RELU = 1'b1
    } act_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        DRAIN  = 3'd2,
        FINISH = 3'd3,
        OUT    = 3'd4
    } state_t;

    // Accumulator width that cannot overflow for an in-element dot product plus bias
    function automatic int acc_width(input int width, input int in);
        return 2 * width + $clog2(in) + 1;
    endfunction

endpackage

// File: rtl/fc_lane_mac.sv
// rtl/fc_lane_mac.sv - per-lane product registers and registered lane-sum adder tree
module fc_lane_mac
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int SUM_W = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic [LANES-1:0]         lane_en,
    input  logic [LANES*WIDTH-1:0]   x,
    input  logic [LANES*WIDTH-1:0]   w,
    output logic                     s1_pending,
    output logic                     sum_valid,
    output logic                     sum_first,
    output logic signed [SUM_W-1:0]  sum
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0]    xe        [LANES];
    logic signed [PW-1:0]    we        [LANES];
    logic signed [PW-1:0]    lane_prod [LANES];
    logic signed [PW-1:0]    prod_q    [LANES];
    logic                    s1_valid_q;
    logic                    s1_first_q;
    logic signed [SUM_W-1:0] lane_total;

    // Sign-extend each lane to product width and multiply; masked lanes contribute zero
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            xe[i]        = PW'($signed(x[i*WIDTH +: WIDTH]));
            we[i]        = PW'($signed(w[i*WIDTH +: WIDTH]));
            lane_prod[i] = lane_en[i] ? (xe[i] * we[i]) : '0;
        end
    end

    // S1: register the lane products together with the beat's valid and first-beat flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= in_valid;
            s1_first_q <= in_first;
            if (in_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    prod_q[i] <= lane_prod[i];
                end
            end
        end
    end

    // Lane-sum adder tree, each product sign-extended to the accumulator width
    always_comb begin
        lane_total = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_total = lane_total + SUM_W'(prod_q[i]);
        end
    end

    // S2: register the lane sum so the accumulator sees one clean operand per beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid <= 1'b0;
            sum_first <= 1'b0;
            sum       <= '0;
        end else begin
            sum_valid <= s1_valid_q;
            sum_first <= s1_first_q;
            if (s1_valid_q) begin
                sum <= lane_total;
            end
        end
    end

    assign s1_pending = s1_valid_q;

endmodule

// File: rtl/fc_neuron_seq.sv
// rtl/fc_neuron_seq.sv - time-multiplexed fully-connected neuron with valid/ready streams
module fc_neuron_seq
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IN    = 400,
    parameter int LANES = 4,
    parameter int ACT   = 1,
    parameter int ACC_W = acc_width(WIDTH, IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   x,
    input  logic [LANES*WIDTH-1:0]   w,
    input  logic [ACC_W-2:0]         bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         z,
    output logic                     busy
);

    localparam int BEATS   = (IN + LANES - 1) / LANES;
    localparam int CNT_W   = $clog2(BEATS + 1);
    localparam bit RELU_EN = (ACT == int'(ACT_RELU));

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] pre_act;
    logic [LANES-1:0]        lane_en;
    logic                    xfer;
    logic                    last_beat;
    logic                    first_beat;
    logic                    s1_pending;
    logic                    sum_valid;
    logic                    sum_first;
    logic signed [ACC_W-1:0] lane_sum;

    assign xfer       = in_valid && in_ready;
    assign first_beat = (state_q == IDLE);
    assign last_beat  = (state_q == IDLE) ? (BEATS == 1) : (cnt_q == CNT_W'(BEATS - 1));

    // Lanes past the end of the vector on the final beat are masked off
    always_comb begin
        lane_en = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_en[i] = ((int'(cnt_q) * LANES + i) < IN);
        end
    end

    fc_lane_mac #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .SUM_W (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (xfer),
        .in_first   (first_beat),
        .lane_en    (lane_en),
        .x          (x),
        .w          (w),
        .s1_pending (s1_pending),
        .sum_valid  (sum_valid),
        .sum_first  (sum_first),
        .sum        (lane_sum)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and in_ready decode; in_ready depends only on the current state
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (BEATS == 1) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_pending && !sum_valid) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat counter: counts accepted beats, cleared when the result is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == OUT && out_ready) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Accumulator: the first beat of a vector loads, later beats add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (sum_valid) begin
            acc_q <= sum_first ? lane_sum : (acc_q + lane_sum);
        end
    end

    assign pre_act = acc_q + ACC_W'($signed(bias));

    // Output register: capture the activated result in FINISH, hold it until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z         <= '0;
            out_valid <= 1'b0;
        end else if (state_q == FINISH) begin
            z         <= (RELU_EN && pre_act[ACC_W-1]) ? '0 : pre_act;
            out_valid <= 1'b1;
        end else if (state_q == OUT && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE) || (cnt_q != '0);

endmodule
